// File: rtl/cmd_uart_bridge.sv
// UART front end: assembles 3-byte host commands into cmd/cmd_rdy and
// serialises single-byte core responses onto TX (8N1, LSB first).
module cmd_uart_bridge #(
   parameter int CLKS_PER_BIT = 2604,
   parameter int TIMEOUT_BITS = 30
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RX,
   output logic        TX,
   output logic [23:0] cmd,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   input  logic [7:0]  resp_data,
   input  logic        send_resp,
   output logic        resp_sent,
   output logic        frm_err,
   output logic        ovr
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] BIT_PENULT = CNT_W'(CLKS_PER_BIT - 2);
   localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int TO_W = $clog2(TO_CYCLES);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

   logic              rx_meta_q, rx_s_q;
   uart_state_e       rx_state_q, rx_state_d;
   logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
   logic [2:0]        rx_bit_q, rx_bit_d;
   logic [7:0]        rx_shift_q, rx_shift_d;
   logic              rx_ferr_q, rx_ferr_d;
   logic              byte_acc, ferr_evt;

   logic [1:0]        byte_cnt_q, byte_cnt_d;
   logic [15:0]       shadow_q, shadow_d;
   logic [23:0]       cmd_q, cmd_d;
   logic              cmd_rdy_q, cmd_rdy_d;
   logic              frm_err_q, frm_err_d;
   logic              ovr_q, ovr_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;

   uart_state_e       tx_state_q, tx_state_d;
   logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
   logic [2:0]        tx_bit_q, tx_bit_d;
   logic [7:0]        tx_shift_q, tx_shift_d;
   logic              tx_q, tx_d;
   logic              resp_sent_q, resp_sent_d;

   assign TX        = tx_q;
   assign cmd       = cmd_q;
   assign cmd_rdy   = cmd_rdy_q;
   assign resp_sent = resp_sent_q;
   assign frm_err   = frm_err_q;
   assign ovr       = ovr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_q   <= 1'b1;
         rx_s_q      <= 1'b1;
         rx_state_q  <= S_IDLE;
         rx_cnt_q    <= '0;
         rx_bit_q    <= '0;
         rx_ferr_q   <= 1'b0;
         byte_cnt_q  <= '0;
         cmd_q       <= '0;
         cmd_rdy_q   <= 1'b0;
         frm_err_q   <= 1'b0;
         ovr_q       <= 1'b0;
         to_cnt_q    <= '0;
         tx_state_q  <= S_IDLE;
         tx_cnt_q    <= '0;
         tx_bit_q    <= '0;
         tx_q        <= 1'b1;
         resp_sent_q <= 1'b0;
      end else begin
         rx_meta_q   <= RX;
         rx_s_q      <= rx_meta_q;
         rx_state_q  <= rx_state_d;
         rx_cnt_q    <= rx_cnt_d;
         rx_bit_q    <= rx_bit_d;
         rx_ferr_q   <= rx_ferr_d;
         byte_cnt_q  <= byte_cnt_d;
         cmd_q       <= cmd_d;
         cmd_rdy_q   <= cmd_rdy_d;
         frm_err_q   <= frm_err_d;
         ovr_q       <= ovr_d;
         to_cnt_q    <= to_cnt_d;
         tx_state_q  <= tx_state_d;
         tx_cnt_q    <= tx_cnt_d;
         tx_bit_q    <= tx_bit_d;
         tx_q        <= tx_d;
         resp_sent_q <= resp_sent_d;
      end
   end

   // Pure datapath registers carry no reset; their contents are qualified by control state.
   always_ff @(posedge clk) begin
      rx_shift_q <= rx_shift_d;
      shadow_q   <= shadow_d;
      tx_shift_q <= tx_shift_d;
   end

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q + 1'b1;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_ferr_d  = rx_ferr_q;
      byte_acc   = 1'b0;
      ferr_evt   = 1'b0;
      case (rx_state_q)
         S_IDLE: begin
            rx_cnt_d  = '0;
            rx_ferr_d = 1'b0;
            if (!rx_s_q) rx_state_d = S_START;
         end
         S_START: begin
            if (rx_cnt_q == HALF_LAST) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = rx_s_q ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_s_q, rx_shift_q[7:1]};
               rx_bit_d   = rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
            end
         end
         S_STOP: begin
            // After a bad stop bit, hold here until the line returns high.
            if (rx_ferr_q) begin
               rx_cnt_d = '0;
               if (rx_s_q) rx_state_d = S_IDLE;
            end else if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d = '0;
               if (rx_s_q) begin
                  byte_acc   = 1'b1;
                  rx_state_d = S_IDLE;
               end else begin
                  ferr_evt  = 1'b1;
                  rx_ferr_d = 1'b1;
               end
            end
         end
         default: rx_state_d = S_IDLE;
      endcase
   end

   always_comb begin
      byte_cnt_d = byte_cnt_q;
      shadow_d   = shadow_q;
      cmd_d      = cmd_q;
      cmd_rdy_d  = cmd_rdy_q & ~clr_cmd_rdy;
      frm_err_d  = ferr_evt;
      ovr_d      = 1'b0;
      to_cnt_d   = '0;
      if (ferr_evt) begin
         byte_cnt_d = '0;
      end else if (byte_acc) begin
         case (byte_cnt_q)
            2'd0: begin
               shadow_d[15:8] = rx_shift_q;
               byte_cnt_d     = 2'd1;
            end
            2'd1: begin
               shadow_d[7:0] = rx_shift_q;
               byte_cnt_d    = 2'd2;
            end
            default: begin
               byte_cnt_d = '0;
               // A pending acknowledge in this same cycle frees the slot for the new command.
               if (cmd_rdy_q && !clr_cmd_rdy) begin
                  ovr_d = 1'b1;
               end else begin
                  cmd_d     = {shadow_q, rx_shift_q};
                  cmd_rdy_d = 1'b1;
               end
            end
         endcase
      end else if (byte_cnt_q != 2'd0 && rx_state_q == S_IDLE) begin
         if (to_cnt_q == TO_LAST) byte_cnt_d = '0;
         else                     to_cnt_d   = to_cnt_q + 1'b1;
      end
   end

   always_comb begin
      tx_state_d  = tx_state_q;
      tx_cnt_d    = tx_cnt_q + 1'b1;
      tx_bit_d    = tx_bit_q;
      tx_shift_d  = tx_shift_q;
      tx_d        = tx_q;
      resp_sent_d = 1'b0;
      case (tx_state_q)
         S_IDLE: begin
            tx_cnt_d = '0;
            tx_d     = 1'b1;
            if (send_resp) begin
               tx_shift_d = resp_data;
               tx_d       = 1'b0;
               tx_state_d = S_START;
            end
         end
         S_START: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
               tx_d       = tx_shift_q[0];
               tx_state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d   = '0;
               tx_shift_d = {1'b0, tx_shift_q[7:1]};
               tx_bit_d   = tx_bit_q + 3'd1;
               if (tx_bit_q == 3'd7) begin
                  tx_d       = 1'b1;
                  tx_state_d = S_STOP;
               end else begin
                  tx_d = tx_shift_q[1];
               end
            end
         end
         S_STOP: begin
            // Registered pulse lands on the final cycle of the stop bit.
            resp_sent_d = (tx_cnt_q == BIT_PENULT);
            if (tx_cnt_q == BIT_LAST) tx_state_d = S_IDLE;
         end
         default: tx_state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_cmd_uart_bridge.sv
// Directed bench for cmd_uart_bridge at 16 clocks per bit.
module tb_cmd_uart_bridge;

   localparam int CPB = 16;

   logic        clk;
   logic        rst;
   logic        RX;
   logic        TX;
   logic [23:0] cmd;
   logic        cmd_rdy;
   logic        clr_cmd_rdy;
   logic [7:0]  resp_data;
   logic        send_resp;
   logic        resp_sent;
   logic        frm_err;
   logic        ovr;

   int checks = 0;
   int errors = 0;
   int frm_cnt = 0;
   int ovr_cnt = 0;
   int sent_cnt = 0;
   int base_a, base_b;
   logic rdy_pre, rdy_post;
   logic [9:0] tx_pat;

   cmd_uart_bridge #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(30)) dut (
      .clk(clk), .rst(rst), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
      .clr_cmd_rdy(clr_cmd_rdy), .resp_data(resp_data), .send_resp(send_resp),
      .resp_sent(resp_sent), .frm_err(frm_err), .ovr(ovr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frm_err)   frm_cnt++;
      if (ovr)       ovr_cnt++;
      if (resp_sent) sent_cnt++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Sends one frame; clr_at selects a frame cycle in which clr_cmd_rdy is held high.
   task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int clr_at);
      logic [9:0] frame;
      int cyc;
      frame = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         RX = frame[i];
         for (int j = 0; j < CPB; j++) begin
            cyc = i * CPB + j;
            clr_cmd_rdy = (cyc == clr_at);
            if (cyc == 154) rdy_pre = cmd_rdy;
            if (cyc == 155) rdy_post = cmd_rdy;
            @(negedge clk);
         end
      end
      clr_cmd_rdy = 1'b0;
      RX = 1'b1;
      if (!stop_bit) idle(CPB);
   endtask

   task automatic pulse_clr();
      clr_cmd_rdy = 1'b1;
      @(negedge clk);
      clr_cmd_rdy = 1'b0;
   endtask

   initial begin
      rst = 1'b1; RX = 1'b1; clr_cmd_rdy = 1'b0; resp_data = 8'h00; send_resp = 1'b0;
      rdy_pre = 1'b0; rdy_post = 1'b0;
      tx_pat = 10'h34A;
      idle(3);
      check("rst_tx", TX, 1);
      check("rst_cmd", cmd, 0);
      check("rst_cmd_rdy", cmd_rdy, 0);
      check("rst_resp_sent", resp_sent, 0);
      check("rst_frm_err", frm_err, 0);
      check("rst_ovr", ovr, 0);
      rst = 1'b0;
      idle(5);

      // basic command and acknowledge
      send_byte(8'h81, 1'b1, -1);
      send_byte(8'h02, 1'b1, -1);
      send_byte(8'h3C, 1'b1, -1);
      check("rdy_at_stop_sample", rdy_pre, 0);
      check("rdy_after_stop_sample", rdy_post, 1);
      check("cmd_basic", cmd, 24'h81023C);
      pulse_clr();
      check("clr_rdy", cmd_rdy, 0);
      check("clr_cmd_held", cmd, 24'h81023C);

      // transmit 0xA5 with an ignored second request mid-frame
      base_a = sent_cnt;
      resp_data = 8'hA5;
      send_resp = 1'b1;
      for (int k = 1; k <= 170; k++) begin
         @(negedge clk);
         send_resp = (k == 80);
         if (k == 80) resp_data = 8'h00;
         if (k <= 160 && ((k - 1) % CPB) == 8)
            check($sformatf("tx_bit%0d", (k - 1) / CPB), TX, tx_pat[(k - 1) / CPB]);
         if (k == 159) check("resp_sent_early", resp_sent, 0);
         if (k == 160) check("resp_sent_at_160", resp_sent, 1);
         if (k == 161) check("resp_sent_after", resp_sent, 0);
      end
      check("tx_idle_after", TX, 1);
      idle(200);
      check("resp_sent_count", sent_cnt - base_a, 1);

      // framing error then a clean command
      base_a = frm_cnt;
      send_byte(8'h11, 1'b1, -1);
      send_byte(8'h22, 1'b0, -1);
      idle(20);
      check("frm_err_count", frm_cnt - base_a, 1);
      check("frm_no_rdy", cmd_rdy, 0);
      send_byte(8'hAA, 1'b1, -1);
      send_byte(8'hBB, 1'b1, -1);
      send_byte(8'hCC, 1'b1, -1);
      check("cmd_after_frm", cmd, 24'hAABBCC);
      check("rdy_after_frm", cmd_rdy, 1);
      check("frm_err_once", frm_cnt - base_a, 1);
      pulse_clr();

      // overrun, then completion coinciding with acknowledge
      base_b = ovr_cnt;
      send_byte(8'h01, 1'b1, -1);
      send_byte(8'h02, 1'b1, -1);
      send_byte(8'h03, 1'b1, -1);
      check("cmd_first", cmd, 24'h010203);
      send_byte(8'h04, 1'b1, -1);
      send_byte(8'h05, 1'b1, -1);
      send_byte(8'h06, 1'b1, -1);
      check("ovr_count", ovr_cnt - base_b, 1);
      check("ovr_cmd_kept", cmd, 24'h010203);
      check("ovr_rdy_kept", cmd_rdy, 1);
      send_byte(8'h04, 1'b1, -1);
      send_byte(8'h05, 1'b1, -1);
      send_byte(8'h06, 1'b1, 154);
      check("set_wins_cmd", cmd, 24'h040506);
      check("set_wins_rdy", cmd_rdy, 1);
      check("set_wins_no_ovr", ovr_cnt - base_b, 1);
      pulse_clr();

      // inter-byte timeout and start-bit glitch
      base_a = frm_cnt;
      send_byte(8'h55, 1'b1, -1);
      idle(31 * CPB);
      send_byte(8'h10, 1'b1, -1);
      RX = 1'b0;
      idle(3);
      RX = 1'b1;
      idle(40);
      check("glitch_no_rdy", cmd_rdy, 0);
      send_byte(8'h20, 1'b1, -1);
      send_byte(8'h30, 1'b1, -1);
      check("cmd_after_timeout", cmd, 24'h102030);
      check("glitch_no_frm", frm_cnt - base_a, 0);
      pulse_clr();

      // reset in the middle of an RX frame and a TX frame
      send_byte(8'h77, 1'b1, -1);
      base_a = sent_cnt;
      base_b = frm_cnt;
      resp_data = 8'h3C;
      send_resp = 1'b1;
      RX = 1'b0;
      @(negedge clk);
      send_resp = 1'b0;
      idle(CPB - 1);
      idle(4 * CPB);
      RX = 1'b1;
      idle(CPB / 2);
      rst = 1'b1;
      idle(2);
      check("midrst_tx_in_rst", TX, 1);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_tx_after", TX, 1);
      check("midrst_cmd", cmd, 0);
      idle(300);
      check("midrst_no_resp_sent", sent_cnt - base_a, 0);
      check("midrst_no_frm", frm_cnt - base_b, 0);
      send_byte(8'hDE, 1'b1, -1);
      send_byte(8'hAD, 1'b1, -1);
      send_byte(8'hBE, 1'b1, -1);
      check("midrst_cmd_next", cmd, 24'hDEADBE);
      check("midrst_rdy_next", cmd_rdy, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
